reg_display_scanner: RTL

REG_DISPLAY_SCANNER -- requirements
Module: reg_display_scanner

---
 rtl/reg_display_pkg.sv | 42 ++++
 rtl/hex_to_seg7.sv | 14 +
 rtl/reg_display_scanner.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/reg_display_pkg.sv
// Shared constants for the register display scanner: digit count,
// digit-enable reset pattern and the seven-segment hex glyph table.
package reg_display_pkg;

  // Number of hex digits on the display and the width of the digit index.
  localparam int DIGITS  = 8;
  localparam int DIGIT_W = 3;

  // Digit enables are active-low; digit 0 is the one lit after reset.
  localparam logic [7:0] AN_RESET  = 8'hFE;
  // Glyph for '0', shown while the snapshot is cleared.
  localparam logic [6:0] SEG_RESET = 7'h40;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Active-low segment patterns ordered {g,f,e,d,c,b,a}; b and d are lower-case.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] glyph;
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder (active-low, {g,f,e,d,c,b,a}).
module hex_to_seg7
  import reg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup lives in the package so the top and any other user agree.
  always_comb begin
    seg = seg_glyph(nibble);
  end

endmodule

// File: rtl/reg_display_scanner.sv
// Steps through a 32-entry register file with a debounced button or an
// auto-scroll timer, and multiplexes the selected register onto an
// eight-digit seven-segment display as hex.
module reg_display_scanner
  import reg_display_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REFRESH_CYC  = 100_000,
  parameter int AUTO_CYC     = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_btn,
  input  logic             auto_en,
  input  logic [WIDTH-1:0] reg_data,
  output logic [4:0]       reg_sel,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int REF_W  = (REFRESH_CYC  > 1) ? $clog2(REFRESH_CYC)  : 1;
  localparam int AUTO_W = (AUTO_CYC     > 1) ? $clog2(AUTO_CYC)     : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYC - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYC - 1);
  localparam digit_t            DIGIT_LAST = digit_t'(DIGITS - 1);

  // Button path
  logic [1:0]        btn_sync_reg;
  logic              btn_stable;
  logic              db_level_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic              db_done;
  logic              btn_pulse;

  // Auto-scroll path
  logic [AUTO_W-1:0] auto_cnt_reg;
  logic              auto_pulse;

  // Register index
  logic              step_pulse;
  logic [4:0]        reg_sel_reg;

  // Display refresh
  logic [REF_W-1:0]  ref_cnt_reg;
  logic              ref_done;
  digit_t            digit_reg;
  logic              frame_wrap;
  logic [WIDTH-1:0]  snapshot_reg;
  logic [3:0]        nibbles [DIGITS];
  logic [3:0]        cur_nibble;

  // Output stage
  logic [7:0]        an_next;
  logic [6:0]        seg_next;
  logic              dp_next;
  logic [7:0]        an_reg;
  logic [6:0]        seg_reg;
  logic              dp_reg;

  // Two-flop synchroniser; nothing downstream sees the raw button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_sync_reg <= 2'b00;
    end else begin
      btn_sync_reg <= {btn_sync_reg[0], step_btn};
    end
  end

  assign btn_stable = btn_sync_reg[1];

  // A candidate level is accepted on the DEBOUNCE_CYC-th consecutive cycle it
  // differs from the current level; returning to the current level restarts.
  assign db_done   = (btn_stable != db_level_reg) && (db_cnt_reg == DB_LAST);
  assign btn_pulse = db_done && btn_stable;

  // Debounce counter and accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level_reg <= 1'b0;
      db_cnt_reg   <= '0;
    end else if (btn_stable == db_level_reg) begin
      db_cnt_reg   <= '0;
    end else if (db_done) begin
      db_level_reg <= btn_stable;
      db_cnt_reg   <= '0;
    end else begin
      db_cnt_reg   <= db_cnt_reg + 1'b1;
    end
  end

  // Auto-scroll timer: fires once every AUTO_CYC enabled cycles, held clear
  // while disabled so enabling always yields a full first period.
  assign auto_pulse = auto_en && (auto_cnt_reg == AUTO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt_reg <= '0;
    end else if (!auto_en || auto_pulse) begin
      auto_cnt_reg <= '0;
    end else begin
      auto_cnt_reg <= auto_cnt_reg + 1'b1;
    end
  end

  // Button and auto pulses are ORed so a coincidence advances by one.
  assign step_pulse = btn_pulse | auto_pulse;

  // Register index, wraps naturally at 5 bits (31 -> 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_sel_reg <= 5'd0;
    end else if (step_pulse) begin
      reg_sel_reg <= reg_sel_reg + 5'd1;
    end
  end

  assign ref_done   = (ref_cnt_reg == REF_LAST);
  assign frame_wrap = ref_done && (digit_reg == DIGIT_LAST);

  // Per-digit dwell counter and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_reg <= '0;
      digit_reg   <= '0;
    end else if (ref_done) begin
      ref_cnt_reg <= '0;
      digit_reg   <= digit_reg + 1'b1;
    end else begin
      ref_cnt_reg <= ref_cnt_reg + 1'b1;
    end
  end

  // Snapshot taken only as the index wraps to digit 0, so one frame always
  // shows a single coherent register value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot_reg <= '0;
    end else if (frame_wrap) begin
      snapshot_reg <= reg_data;
    end
  end

  // Split the snapshot into per-digit nibbles; digits beyond WIDTH read zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    if (gi * 4 + 3 < WIDTH) begin : g_full
      assign nibbles[gi] = snapshot_reg[gi*4 +: 4];
    end else begin : g_pad
      assign nibbles[gi] = 4'h0;
    end
  end

  assign cur_nibble = nibbles[digit_reg];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (seg_next)
  );

  // Next values for the display pins, derived from the current digit index.
  always_comb begin
    an_next = 8'hFF;
    dp_next = 1'b1;
    an_next[digit_reg] = 1'b0;
    if ((digit_reg == '0) && auto_en) begin
      dp_next = 1'b0;
    end
  end

  // Display pins are registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg  <= AN_RESET;
      seg_reg <= SEG_RESET;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign reg_sel = reg_sel_reg;
  assign an      = an_reg;
  assign seg     = seg_reg;
  assign dp      = dp_reg;

endmodule
